// File: rtl/hqm_aw_cfg_initiator_pkg.sv
// Shared types for the CFG initiator: request payload, FSM state and response record.
`default_nettype none

package hqm_aw_cfg_initiator_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
  } cfg_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RSP   = 2'd3
  } cfg_init_state_t;

  typedef struct packed {
    logic        err;
    logic        timeout;
    logic [31:0] rdata;
  } cfg_init_rsp_t;

  // floor(log2(value)); +1 gives the bits needed to hold value itself
  function automatic int aw_logb2(input int value);
    int r;
    r = 0;
    for (int v = value; v > 1; v = v >> 1) r = r + 1;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hqm_aw_cfg_initiator_if.sv
// Request/response and broadcast CFG bus between the initiator (master) and its environment (slave).
`default_nettype none

interface hqm_aw_cfg_initiator_if #(
  parameter int NUM_TGT = 4
);
  import hqm_aw_cfg_initiator_pkg::*;

  logic                    req_v;
  logic                    req_ready;
  logic                    req_write;
  cfg_req_t                req;
  logic                    rsp_v;
  logic                    rsp_ready;
  logic                    rsp_err;
  logic                    rsp_timeout;
  logic [31:0]             rsp_rdata;
  logic                    cfg_write;
  logic                    cfg_read;
  cfg_req_t                cfg_req;
  logic [NUM_TGT-1:0]      cfg_ack;
  logic [NUM_TGT-1:0]      cfg_err;
  logic [NUM_TGT*32-1:0]   cfg_rdata;
  logic                    busy;
  logic                    error_multi_ack;
  logic                    error_unexp_ack;

  modport master (
    input  req_v, req_write, req, rsp_ready, cfg_ack, cfg_err, cfg_rdata,
    output req_ready, rsp_v, rsp_err, rsp_timeout, rsp_rdata,
           cfg_write, cfg_read, cfg_req, busy, error_multi_ack, error_unexp_ack
  );

  modport slave (
    output req_v, req_write, req, rsp_ready, cfg_ack, cfg_err, cfg_rdata,
    input  req_ready, rsp_v, rsp_err, rsp_timeout, rsp_rdata,
           cfg_write, cfg_read, cfg_req, busy, error_multi_ack, error_unexp_ack
  );

endinterface

`default_nettype wire

// File: rtl/hqm_aw_cfg_initiator_ack_merge.sv
// Combinational merge of per-target ack/err/rdata: any/multi ack flags, qualified err OR, AND-OR rdata.
`default_nettype none

module hqm_aw_cfg_initiator_ack_merge #(
  parameter int NUM_TGT = 4
) (
  input  wire logic [NUM_TGT-1:0]    i_ack,
  input  wire logic [NUM_TGT-1:0]    i_err,
  input  wire logic [NUM_TGT*32-1:0] i_rdata,
  output logic                       o_any,
  output logic                       o_multi,
  output logic                       o_err,
  output logic [31:0]                o_rdata
);

  logic        w_any;
  logic        w_multi;
  logic        w_err;
  logic [31:0] w_rdata;

  // multi is set by any ack that follows an earlier ack in the scan
  always_comb begin
    w_any   = 1'b0;
    w_multi = 1'b0;
    w_err   = 1'b0;
    w_rdata = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      w_multi = w_multi | (w_any & i_ack[i]);
      w_any   = w_any | i_ack[i];
      w_err   = w_err | (i_ack[i] & i_err[i]);
      w_rdata = w_rdata | ({32{i_ack[i]}} & i_rdata[32*i +: 32]);
    end
  end

  assign o_any   = w_any;
  assign o_multi = w_multi;
  assign o_err   = w_err;
  assign o_rdata = w_rdata;

endmodule

`default_nettype wire

// File: rtl/hqm_aw_cfg_initiator.sv
// CFG initiator: broadcasts one cfg request to NUM_TGT targets, collects one ack, returns a response.
// Optional macro HQM_AW_CFG_INITIATOR_TIMEOUT_EN enables the WAIT timeout counter.
`default_nettype none

module hqm_aw_cfg_initiator #(
  parameter int NUM_TGT = 4,
  parameter int TIMEOUT = 1023
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  hqm_aw_cfg_initiator_if.master     cfg_if
);
  import hqm_aw_cfg_initiator_pkg::*;

  cfg_init_state_t r_state;
  cfg_init_state_t w_state_nxt;
  cfg_req_t        r_req;
  logic            r_write;
  cfg_init_rsp_t   r_rsp;
  logic            r_err_multi;
  logic            r_err_unexp;

  logic            w_any_ack;
  logic            w_multi_ack;
  logic            w_merge_err;
  logic [31:0]     w_merge_rdata;
  logic            w_timeout_hit;
  logic            w_in_wait;

  hqm_aw_cfg_initiator_ack_merge #(
    .NUM_TGT (NUM_TGT)
  ) u_ack_merge (
    .i_ack   (cfg_if.cfg_ack),
    .i_err   (cfg_if.cfg_err),
    .i_rdata (cfg_if.cfg_rdata),
    .o_any   (w_any_ack),
    .o_multi (w_multi_ack),
    .o_err   (w_merge_err),
    .o_rdata (w_merge_rdata)
  );

  assign w_in_wait = (r_state == WAIT);

`ifdef HQM_AW_CFG_INITIATOR_TIMEOUT_EN
  localparam int                 TOWIDTH = aw_logb2(TIMEOUT) + 1;
  localparam logic [TOWIDTH-1:0] TO_MAX  = TOWIDTH'(TIMEOUT);
  localparam logic [TOWIDTH-1:0] TO_LAST = TOWIDTH'(TIMEOUT - 1);

  logic [TOWIDTH-1:0] r_to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if (r_state == ISSUE) begin
      r_to_cnt <= '0;
    end else if (w_in_wait && (r_to_cnt != TO_MAX)) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // fires in the TIMEOUT-th WAIT cycle, so RSP follows exactly TIMEOUT WAIT cycles
  assign w_timeout_hit = w_in_wait && (r_to_cnt == TO_LAST);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT > 0);
  assign w_timeout_hit    = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (cfg_if.req_v)              w_state_nxt = ISSUE;
      ISSUE:                                  w_state_nxt = WAIT;
      WAIT:    if (w_any_ack || w_timeout_hit) w_state_nxt = RSP;
      RSP:     if (cfg_if.rsp_ready)          w_state_nxt = IDLE;
      default:                                w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req       <= '0;
      r_write     <= 1'b0;
      r_rsp       <= '0;
      r_err_multi <= 1'b0;
      r_err_unexp <= 1'b0;
    end else begin
      r_err_multi <= w_in_wait & w_multi_ack;
      r_err_unexp <= ~w_in_wait & w_any_ack;
      if ((r_state == IDLE) && cfg_if.req_v) begin
        r_req   <= cfg_if.req;
        r_write <= cfg_if.req_write;
        r_rsp   <= '0;
      end else if (w_in_wait && w_any_ack) begin
        // read data is only returned for a clean single-target read
        r_rsp.err     <= w_multi_ack | w_merge_err;
        r_rsp.timeout <= 1'b0;
        r_rsp.rdata   <= (w_multi_ack || w_merge_err || r_write) ? 32'h0 : w_merge_rdata;
      end else if (w_timeout_hit) begin
        r_rsp.err     <= 1'b1;
        r_rsp.timeout <= 1'b1;
        r_rsp.rdata   <= 32'h0;
      end
    end
  end

  assign cfg_if.req_ready       = (r_state == IDLE);
  assign cfg_if.busy            = (r_state != IDLE);
  assign cfg_if.cfg_write       = (r_state == ISSUE) &  r_write;
  assign cfg_if.cfg_read        = (r_state == ISSUE) & ~r_write;
  assign cfg_if.cfg_req         = r_req;
  assign cfg_if.rsp_v           = (r_state == RSP);
  assign cfg_if.rsp_err         = r_rsp.err;
  assign cfg_if.rsp_timeout     = r_rsp.timeout;
  assign cfg_if.rsp_rdata       = r_rsp.rdata;
  assign cfg_if.error_multi_ack = r_err_multi;
  assign cfg_if.error_unexp_ack = r_err_unexp;

endmodule

`default_nettype wire

// File: tb/tb_hqm_aw_cfg_initiator.sv
// Table-driven bench for hqm_aw_cfg_initiator with a response scoreboard and hand-written corner sequences.
`default_nettype none

module tb_hqm_aw_cfg_initiator;
  import hqm_aw_cfg_initiator_pkg::*;

  localparam int NT  = 4;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hqm_aw_cfg_initiator_if #(.NUM_TGT(NT)) bus ();

  hqm_aw_cfg_initiator #(
    .NUM_TGT (NT),
    .TIMEOUT (TMO)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cfg_if (bus.master)
  );

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    int           ack_dly;   // WAIT cycle in which acks appear; 0 = never
    logic [3:0]   ack;
    logic [3:0]   err;
    logic [127:0] rd;
    int           hold;      // cycles rsp_ready stays low
    int           stray;     // RSP cycle in which a late ack is driven; 0 = none
    bit           pend;      // present a competing request during RSP
    int           exp_wait;
    logic         e_err;
    logic         e_to;
    logic [31:0]  e_rd;
    logic         e_multi;
  } vec_t;

  typedef struct packed {
    logic        err;
    logic        to;
    logic [31:0] rd;
    logic        multi;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input int dly, input logic [3:0] ack, input logic [3:0] err,
                              input logic [127:0] rd, input int hold, input int stray, input bit pend,
                              input int ew, input logic e_err, input logic e_to,
                              input logic [31:0] e_rd, input logic e_multi);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.ack_dly = dly; v.ack = ack; v.err = err;
    v.rd = rd; v.hold = hold; v.stray = stray; v.pend = pend; v.exp_wait = ew;
    v.e_err = e_err; v.e_to = e_to; v.e_rd = e_rd; v.e_multi = e_multi;
    return v;
  endfunction

  task automatic do_txn(input vec_t v);
    cfg_req_t p;
    exp_t     e;
    int       k;
    p.addr  = v.addr;
    p.wdata = v.wdata;
    @(negedge clk);
    chk("idle_req_ready", bus.req_ready, 1);
    bus.req_v     = 1'b1;
    bus.req_write = v.wr;
    bus.req       = p;
    bus.cfg_err   = v.err;
    bus.cfg_rdata = v.rd;
    sb.push_back('{err: v.e_err, to: v.e_to, rd: v.e_rd, multi: v.e_multi});
    @(negedge clk);
    bus.req_v = 1'b0;
    chk("issue_cfg_write", bus.cfg_write, v.wr);
    chk("issue_cfg_read", bus.cfg_read, !v.wr);
    chk("issue_cfg_req", bus.cfg_req, p);
    chk("issue_busy", bus.busy, 1);
    chk("issue_req_ready", bus.req_ready, 0);
    k = 0;
    @(negedge clk);
    while (!bus.rsp_v && k < 200) begin
      k++;
      chk("wait_strobes", {bus.cfg_write, bus.cfg_read}, 0);
      chk("wait_err_pulses", {bus.error_multi_ack, bus.error_unexp_ack}, 0);
      bus.cfg_ack = (k == v.ack_dly) ? v.ack : 4'b0000;
      @(negedge clk);
      bus.cfg_ack = 4'b0000;
    end
    chk("wait_cycles", k, v.exp_wait);
    if (!bus.rsp_v) begin
      void'(sb.pop_front());
      return;
    end
    if (sb.size() == 0) begin
      chk("sb_nonempty", 0, 1);
      return;
    end
    e = sb.pop_front();
    for (int j = 1; j <= v.hold + 1; j++) begin
      chk("rsp_v", bus.rsp_v, 1);
      chk("rsp_err", bus.rsp_err, e.err);
      chk("rsp_timeout", bus.rsp_timeout, e.to);
      chk("rsp_rdata", bus.rsp_rdata, e.rd);
      chk("rsp_req_ready", bus.req_ready, 0);
      chk("rsp_busy", bus.busy, 1);
      chk("rsp_cfg_req", bus.cfg_req, p);
      chk("multi_pulse", bus.error_multi_ack, (j == 1) ? e.multi : 1'b0);
      chk("unexp_pulse", bus.error_unexp_ack, (v.stray != 0 && j == v.stray + 1));
      bus.cfg_ack   = (j == v.stray) ? 4'b0001 : 4'b0000;
      bus.rsp_ready = (j == v.hold + 1);
      if (v.pend) begin
        bus.req_v     = 1'b1;
        bus.req_write = 1'b1;
        bus.req       = '{addr: ~v.addr, wdata: 32'h5555_AAAA};
      end
      @(negedge clk);
    end
    bus.rsp_ready = 1'b0;
    bus.req_v     = 1'b0;
    bus.cfg_ack   = 4'b0000;
    chk("post_rsp_v", bus.rsp_v, 0);
    chk("post_req_ready", bus.req_ready, 1);
    chk("post_busy", bus.busy, 0);
    chk("post_err_pulses", {bus.error_multi_ack, bus.error_unexp_ack}, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, bus.req_ready, 1);
    chk({tag, "_rsp_v"}, bus.rsp_v, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_strobes"}, {bus.cfg_write, bus.cfg_read}, 0);
    chk({tag, "_cfg_req"}, bus.cfg_req, 0);
    chk({tag, "_rsp"}, {bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata}, 0);
    chk({tag, "_err_pulses"}, {bus.error_multi_ack, bus.error_unexp_ack}, 0);
  endtask

  initial begin
    vecs.push_back(mk(0, 32'h100, 32'h0, 1, 4'b0100, 4'b1000,
                      {32'h33333333, 32'hDEADBEEF, 32'h11111111, 32'h0BADF00D},
                      0, 0, 0, 1, 0, 0, 32'hDEADBEEF, 0));
    vecs.push_back(mk(1, 32'h204, 32'hA5A50001, 5, 4'b0001, 4'b0001,
                      {32'h33333333, 32'hDEADBEEF, 32'h11111111, 32'h0BADF00D},
                      3, 0, 0, 5, 1, 0, 32'h0, 0));
    vecs.push_back(mk(0, 32'h308, 32'h0, 2, 4'b1010, 4'b0000,
                      {32'h0000BBBB, 32'h0, 32'hAAAA0000, 32'h0},
                      2, 0, 0, 2, 1, 0, 32'h0, 1));
    vecs.push_back(mk(0, 32'h40C, 32'h0, 1, 4'b1000, 4'b0111,
                      {32'hCAFEF00D, 32'h1, 32'h2, 32'h3},
                      10, 0, 1, 1, 0, 0, 32'hCAFEF00D, 0));
    vecs.push_back(mk(0, 32'h510, 32'h0, 3, 4'b0001, 4'b0000,
                      {32'h1, 32'h2, 32'h3, 32'h12345678},
                      4, 2, 0, 3, 0, 0, 32'h12345678, 0));
`ifdef HQM_AW_CFG_INITIATOR_TIMEOUT_EN
    vecs.push_back(mk(0, 32'h614, 32'h0, 0, 4'b0100, 4'b0000,
                      {32'h0, 32'h5A5A5A5A, 32'h0, 32'h0},
                      4, 2, 0, TMO, 1, 1, 32'h0, 0));
`else
    vecs.push_back(mk(0, 32'h614, 32'h0, 20, 4'b0100, 4'b0000,
                      {32'h0, 32'h5A5A5A5A, 32'h0, 32'h0},
                      4, 2, 0, 20, 0, 0, 32'h5A5A5A5A, 0));
`endif
    vecs.push_back(mk(1, 32'h718, 32'h00000F0F, 1, 4'b1000, 4'b0000,
                      {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
                      0, 0, 0, 1, 0, 0, 32'h0, 0));

    rst_n         = 1'b0;
    bus.req_v     = 1'b0;
    bus.req_write = 1'b0;
    bus.req       = '0;
    bus.rsp_ready = 1'b0;
    bus.cfg_ack   = '0;
    bus.cfg_err   = '0;
    bus.cfg_rdata = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("after_reset");

    // stray (double) ack while idle: flagged as unexpected, not as multi, state untouched
    bus.cfg_ack = 4'b0110;
    @(negedge clk);
    bus.cfg_ack = 4'b0000;
    chk("idle_ack_unexp", bus.error_unexp_ack, 1);
    chk("idle_ack_multi", bus.error_multi_ack, 0);
    chk("idle_ack_busy", bus.busy, 0);
    chk("idle_ack_ready", bus.req_ready, 1);
    @(negedge clk);
    chk("idle_ack_unexp_clr", bus.error_unexp_ack, 0);

    for (int i = 0; i < vecs.size(); i++) do_txn(vecs[i]);

    // reset in WAIT: outputs return to reset values at once, next transaction is clean
    @(negedge clk);
    bus.req_v     = 1'b1;
    bus.req_write = 1'b0;
    bus.req       = '{addr: 32'h9F0, wdata: 32'h0};
    @(negedge clk);
    bus.req_v = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("post_mid_reset");
    do_txn(vecs[0]);

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
